// File: rtl/satatx_arbiter.sv
// satatx_arbiter: frame-granular 2:1 AXI-stream arbiter in front of the TX CRC
// stage. S0 carries command/register FIS traffic, S1 carries data FIS traffic.
// The grant is held from a frame's first beat through its TLAST. An optional
// inter-frame gap leaves room for the link layer to insert CRC/EOF primitives.
//
// Build option: define SATA_ARB_LENCHK_EN to enable the frame length check.
// With it, a frame that reaches MAX_WORDS beats without TLAST is cut short:
// its MAX_WORDS-th beat leaves with TLAST forced, o_err_len pulses, and the
// rest of the source frame is swallowed. Without it, frames of any length
// pass through unmodified and o_err_len stays low.

module satatx_arbiter #(
  parameter bit OPT_FIXED_PRI = 1'b0,
  parameter int GAP_CYCLES    = 4,
  parameter int MAX_WORDS     = 2049,
  parameter bit OPT_LOWPOWER  = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,

  input  logic        S0_AXIS_TVALID,
  output logic        S0_AXIS_TREADY,
  input  logic [31:0] S0_AXIS_TDATA,
  input  logic        S0_AXIS_TLAST,

  input  logic        S1_AXIS_TVALID,
  output logic        S1_AXIS_TREADY,
  input  logic [31:0] S1_AXIS_TDATA,
  input  logic        S1_AXIS_TLAST,

  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,

  output logic [1:0]  o_grant,
  output logic        o_busy,
  output logic        o_err_len
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Value of the gap counter on the last idle cycle of the inter-frame gap.
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_srv_q, last_srv_d;   // 1: S1 was served last, 0: S0
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        err_len_q, err_len_d;

`ifdef SATA_ARB_LENCHK_EN
  // Beat index at which an unterminated frame gets cut.
  localparam logic [11:0] LEN_LAST = 12'(MAX_WORDS - 1);

  logic [11:0] beat_cnt_q, beat_cnt_d;
`else
  // MAX_WORDS only matters when length checking is built in.
  logic [11:0] unused_max_words;
  assign unused_max_words = 12'(MAX_WORDS);
`endif

  logic        own_valid;
  logic        own_last;
  logic [31:0] own_data;
  logic        own_ready;
  logic        accept;
  logic        pick_s1;

  // Route the current owner's stream onto a common set of signals.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    if (grant_q[0]) begin
      own_valid = S0_AXIS_TVALID;
      own_last  = S0_AXIS_TLAST;
      own_data  = S0_AXIS_TDATA;
    end else if (grant_q[1]) begin
      own_valid = S1_AXIS_TVALID;
      own_last  = S1_AXIS_TLAST;
      own_data  = S1_AXIS_TDATA;
    end
  end

  // Owner may push a beat when the output register is empty or draining;
  // while discarding an overlong frame it is always ready.
  always_comb begin
    own_ready = 1'b0;
    case (state_q)
      S_GRANT: own_ready = !m_valid_q || M_AXIS_TREADY;
`ifdef SATA_ARB_LENCHK_EN
      S_DRAIN: own_ready = 1'b1;
`endif
      default: own_ready = 1'b0;
    endcase
  end

  assign S0_AXIS_TREADY = grant_q[0] & own_ready;
  assign S1_AXIS_TREADY = grant_q[1] & own_ready;
  assign accept         = own_valid & own_ready;

  // Choose the next owner: a lone requester wins, ties go to S0 under fixed
  // priority, otherwise to whichever source was not served last.
  always_comb begin
    pick_s1 = 1'b0;
    if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
      pick_s1 = OPT_FIXED_PRI ? 1'b0 : !last_srv_q;
    end else begin
      pick_s1 = S1_AXIS_TVALID;
    end
  end

  // Next-state, grant, gap counter and output register update.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_srv_d = last_srv_q;
    gap_cnt_d  = gap_cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    err_len_d  = 1'b0;
`ifdef SATA_ARB_LENCHK_EN
    beat_cnt_d = beat_cnt_q;
`endif

    if (m_valid_q && M_AXIS_TREADY) begin
      m_valid_d = 1'b0;
      if (OPT_LOWPOWER) begin
        m_data_d = '0;
        m_last_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        gap_cnt_d = '0;
        if (S0_AXIS_TVALID || S1_AXIS_TVALID) begin
          grant_d    = pick_s1 ? 2'b10 : 2'b01;
          last_srv_d = pick_s1;
          state_d    = S_GRANT;
`ifdef SATA_ARB_LENCHK_EN
          beat_cnt_d = '0;
`endif
        end
      end

      S_GRANT: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = own_data;
          m_last_d  = own_last;
`ifdef SATA_ARB_LENCHK_EN
          beat_cnt_d = beat_cnt_q + 12'd1;
          if (own_last) begin
            state_d = S_GAP;
          end else if (beat_cnt_q == LEN_LAST) begin
            m_last_d  = 1'b1;
            err_len_d = 1'b1;
            state_d   = S_DRAIN;
          end
`else
          if (own_last) begin
            state_d = S_GAP;
          end
`endif
        end
      end

`ifdef SATA_ARB_LENCHK_EN
      S_DRAIN: begin
        if (own_valid && own_last) begin
          state_d = S_GAP;
        end
      end
`endif

      S_GAP: begin
        if (m_valid_q) begin
          if (M_AXIS_TREADY && (GAP_CYCLES == 0)) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
          end
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          grant_d   = 2'b00;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      last_srv_q <= 1'b1;
      gap_cnt_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_srv_q <= last_srv_d;
      gap_cnt_q  <= gap_cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      err_len_q  <= err_len_d;
    end
  end

`ifdef SATA_ARB_LENCHK_EN
  // Beat counter for the frame currently owning the output.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`endif

  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign o_grant       = grant_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_err_len     = err_len_q;

endmodule

// File: tb/tb_satatx_arbiter.sv
// tb_satatx_arbiter: directed bench for satatx_arbiter. The main instance
// uses round-robin with a 4-cycle gap; a second instance uses fixed priority
// with no gap. Both share stimulus, and the bench observes one at a time.

module tb_satatx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0Valid, s0Last, s1Valid, s1Last, mReady;
  logic [31:0] s0Data, s1Data;

  logic        mS0Ready, mS1Ready, mMValid, mMLast, mBusy, mErr;
  logic [31:0] mMData;
  logic [1:0]  mGrant;
  logic        aS0Ready, aS1Ready, aMValid, aMLast, aBusy, aErr;
  logic [31:0] aMData;
  logic [1:0]  aGrant;

  logic        useAlt;
  logic        vS0Ready, vS1Ready, vMValid, vMLast, vBusy, vErr;
  logic [31:0] vMData;
  logic [1:0]  vGrant;

  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  int          s0Fires = 0;
  int          s1Fires = 0;
  int          errPulses = 0;
  logic [3:0]  readyPat;
  int          readyIdx;
  logic        watchS0;
  logic        prevStall;
  logic        prevLast;
  logic [31:0] prevData;

  logic [32:0] s0Queue[$];
  logic [32:0] s1Queue[$];
  logic [32:0] outQueue[$];
  logic [32:0] expQueue[$];
  int          outCycle[$];
  int          s0FireCycle[$];

  always #5 clk = ~clk;

  satatx_arbiter #(
    .OPT_FIXED_PRI(1'b0), .GAP_CYCLES(4), .MAX_WORDS(4), .OPT_LOWPOWER(1'b1)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(reset),
    .S0_AXIS_TVALID(s0Valid), .S0_AXIS_TREADY(mS0Ready), .S0_AXIS_TDATA(s0Data), .S0_AXIS_TLAST(s0Last),
    .S1_AXIS_TVALID(s1Valid), .S1_AXIS_TREADY(mS1Ready), .S1_AXIS_TDATA(s1Data), .S1_AXIS_TLAST(s1Last),
    .M_AXIS_TVALID(mMValid), .M_AXIS_TREADY(mReady), .M_AXIS_TDATA(mMData), .M_AXIS_TLAST(mMLast),
    .o_grant(mGrant), .o_busy(mBusy), .o_err_len(mErr)
  );

  satatx_arbiter #(
    .OPT_FIXED_PRI(1'b1), .GAP_CYCLES(0), .MAX_WORDS(2049), .OPT_LOWPOWER(1'b1)
  ) dutAlt (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(reset),
    .S0_AXIS_TVALID(s0Valid), .S0_AXIS_TREADY(aS0Ready), .S0_AXIS_TDATA(s0Data), .S0_AXIS_TLAST(s0Last),
    .S1_AXIS_TVALID(s1Valid), .S1_AXIS_TREADY(aS1Ready), .S1_AXIS_TDATA(s1Data), .S1_AXIS_TLAST(s1Last),
    .M_AXIS_TVALID(aMValid), .M_AXIS_TREADY(mReady), .M_AXIS_TDATA(aMData), .M_AXIS_TLAST(aMLast),
    .o_grant(aGrant), .o_busy(aBusy), .o_err_len(aErr)
  );

  assign vS0Ready = useAlt ? aS0Ready : mS0Ready;
  assign vS1Ready = useAlt ? aS1Ready : mS1Ready;
  assign vMValid  = useAlt ? aMValid  : mMValid;
  assign vMData   = useAlt ? aMData   : mMData;
  assign vMLast   = useAlt ? aMLast   : mMLast;
  assign vGrant   = useAlt ? aGrant   : mGrant;
  assign vBusy    = useAlt ? aBusy    : mBusy;
  assign vErr     = useAlt ? aErr     : mErr;

  // Count one comparison and report it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Present the head of each source queue and the current M_TREADY value.
  task automatic driveInputs();
    s0Valid = (s0Queue.size() != 0);
    s1Valid = (s1Queue.size() != 0);
    if (s0Valid) {s0Last, s0Data} = s0Queue[0];
    else {s0Last, s0Data} = 33'd0;
    if (s1Valid) {s1Last, s1Data} = s1Queue[0];
    else {s1Last, s1Data} = 33'd0;
    mReady = readyPat[readyIdx % 4];
    readyIdx++;
  endtask

  // One clock: observe handshakes mid-cycle, then advance the sources.
  task automatic applyStimulus();
    logic s0Fire, s1Fire, mFire;
    @(negedge clk);
    s0Fire = s0Valid && vS0Ready;
    s1Fire = s1Valid && vS1Ready;
    mFire  = vMValid && mReady;
    if (s0Fire) begin
      checkOutput("grant_s0", 64'(vGrant), 64'(2'b01));
      s0Fires++;
      s0FireCycle.push_back(cycle);
    end
    if (s1Fire) begin
      checkOutput("grant_s1", 64'(vGrant), 64'(2'b10));
      s1Fires++;
    end
    if (mFire) begin
      outQueue.push_back({vMLast, vMData});
      outCycle.push_back(cycle);
    end
    if (prevStall) begin
      checkOutput("stall_hold", 64'({vMValid, vMLast, vMData}), 64'({1'b1, prevLast, prevData}));
    end
    prevStall = vMValid && !mReady;
    prevLast  = vMLast;
    prevData  = vMData;
    if (vErr) errPulses++;
    if (watchS0) checkOutput("s0_ready_low", 64'(vS0Ready), 64'(0));
    @(posedge clk);
    #1;
    if (s0Fire) void'(s0Queue.pop_front());
    if (s1Fire) void'(s1Queue.pop_front());
    driveInputs();
    cycle++;
  endtask

  task automatic loadFrame(input int src, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (src == 0) s0Queue.push_back({(i == n - 1), base + 32'(i)});
      else s1Queue.push_back({(i == n - 1), base + 32'(i)});
    end
  endtask

  task automatic expectFrame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) expQueue.push_back({(i == n - 1), base + 32'(i)});
  endtask

  task automatic clearLogs();
    outQueue.delete();
    expQueue.delete();
    outCycle.delete();
    s0FireCycle.delete();
  endtask

  // Run until all queued beats are out and the arbiter is idle again.
  task automatic runUntilQuiet(input string tag, input int budget);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      applyStimulus();
      n++;
      done = (s0Queue.size() == 0) && (s1Queue.size() == 0) && !vBusy && !vMValid;
    end
    checkOutput($sformatf("%s_quiet", tag), 64'(done), 64'(1));
  endtask

  task automatic compareOut(input string tag);
    checkOutput($sformatf("%s_count", tag), 64'(outQueue.size()), 64'(expQueue.size()));
    for (int i = 0; i < expQueue.size() && i < outQueue.size(); i++) begin
      checkOutput($sformatf("%s_beat%0d", tag, i), 64'(outQueue[i]), 64'(expQueue[i]));
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    s0Queue.delete();
    s1Queue.delete();
    driveInputs();
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    prevStall = 1'b0;
    clearLogs();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput($sformatf("%s_grant", tag), 64'(vGrant), 64'(0));
    checkOutput($sformatf("%s_mvalid", tag), 64'(vMValid), 64'(0));
    checkOutput($sformatf("%s_mdata", tag), 64'(vMData), 64'(0));
    checkOutput($sformatf("%s_mlast", tag), 64'(vMLast), 64'(0));
    checkOutput($sformatf("%s_s0ready", tag), 64'(vS0Ready), 64'(0));
    checkOutput($sformatf("%s_s1ready", tag), 64'(vS1Ready), 64'(0));
    checkOutput($sformatf("%s_busy", tag), 64'(vBusy), 64'(0));
    checkOutput($sformatf("%s_err", tag), 64'(vErr), 64'(0));
  endtask

  initial begin
    int loadCycle;
    int base;
    int n;
    useAlt    = 1'b0;
    readyPat  = 4'b1111;
    readyIdx  = 0;
    watchS0   = 1'b0;
    prevStall = 1'b0;
    prevLast  = 1'b0;
    prevData  = '0;
    reset     = 1'b1;
    driveInputs();

    doReset();
    checkIdleOutputs("rst");

    // S0 alone, 3 beats, then a 1-beat frame to measure the gap.
    $display("[TB] single-source frame and inter-frame gap");
    loadCycle = cycle;
    loadFrame(0, 32'hA000_0000, 3);
    loadFrame(0, 32'hA100_0000, 1);
    runUntilQuiet("t1", 200);
    expectFrame(32'hA000_0000, 3);
    expectFrame(32'hA100_0000, 1);
    compareOut("t1");
    checkOutput("t1_first_ready", 64'(s0FireCycle[0] - loadCycle), 64'(2));
    // A2 leaves at handshake h; 4 gap cycles, one idle cycle, one grant cycle.
    if (outCycle.size() >= 3 && s0FireCycle.size() >= 4)
      checkOutput("t1_gap", 64'(s0FireCycle[3] - outCycle[2]), 64'(6));
    else
      checkOutput("t1_gap_seen", 64'(s0FireCycle.size()), 64'(4));
    clearLogs();

    // Round-robin: first tie after reset goes to S0.
    $display("[TB] round-robin arbitration");
    doReset();
    loadFrame(0, 32'hA200_0000, 2);
    loadFrame(1, 32'hB200_0000, 2);
    runUntilQuiet("t2a", 200);
    expectFrame(32'hA200_0000, 2);
    expectFrame(32'hB200_0000, 2);
    compareOut("t2a");
    clearLogs();
    loadFrame(0, 32'hA300_0000, 1);
    runUntilQuiet("t2b", 200);
    loadFrame(0, 32'hA400_0000, 1);
    loadFrame(1, 32'hB400_0000, 1);
    runUntilQuiet("t2c", 200);
    expectFrame(32'hA300_0000, 1);
    expectFrame(32'hB400_0000, 1);
    expectFrame(32'hA400_0000, 1);
    compareOut("t2bc");
    clearLogs();

    // S1 frame under output back-pressure, exactly MAX_WORDS beats long.
    $display("[TB] back-pressure on S1 frame");
    readyPat = 4'b1001;
    readyIdx = 0;
    watchS0  = 1'b1;
    errPulses = 0;
    loadFrame(1, 32'hB000_0000, 4);
    runUntilQuiet("t3", 300);
    watchS0  = 1'b0;
    readyPat = 4'b1111;
    expectFrame(32'hB000_0000, 4);
    compareOut("t3");
    checkOutput("t3_no_err", 64'(errPulses), 64'(0));
    clearLogs();

    // Reset in the middle of a 5-beat frame.
    $display("[TB] mid-frame reset");
    base = s0Fires;
    n = 0;
    loadFrame(0, 32'hC000_0000, 5);
    while (s0Fires < base + 2 && n < 50) begin
      applyStimulus();
      n++;
    end
    checkOutput("t4_two_beats", 64'(s0Fires - base), 64'(2));
    reset = 1'b1;
    s0Queue.delete();
    driveInputs();
    applyStimulus();
    checkOutput("t4_mvalid", 64'(vMValid), 64'(0));
    checkOutput("t4_grant", 64'(vGrant), 64'(0));
    checkOutput("t4_busy", 64'(vBusy), 64'(0));
    checkOutput("t4_s0ready", 64'(vS0Ready), 64'(0));
    reset = 1'b0;
    prevStall = 1'b0;
    clearLogs();
    loadFrame(0, 32'hD000_0000, 3);
    runUntilQuiet("t4", 200);
    expectFrame(32'hD000_0000, 3);
    compareOut("t4");
    clearLogs();

    // 6-beat S1 frame against MAX_WORDS=4.
    $display("[TB] overlong frame");
    errPulses = 0;
    base = s1Fires;
    loadFrame(1, 32'hE000_0000, 6);
    runUntilQuiet("t5", 200);
    checkOutput("t5_consumed", 64'(s1Fires - base), 64'(6));
`ifdef SATA_ARB_LENCHK_EN
    expectFrame(32'hE000_0000, 4);
    compareOut("t5");
    checkOutput("t5_err_pulses", 64'(errPulses), 64'(1));
`else
    expectFrame(32'hE000_0000, 6);
    compareOut("t5");
    checkOutput("t5_err_pulses", 64'(errPulses), 64'(0));
`endif
    clearLogs();

    // Fixed-priority, zero-gap instance: back-to-back single-beat frames.
    $display("[TB] zero-gap back-to-back frames");
    useAlt = 1'b1;
    doReset();
    checkIdleOutputs("alt_rst");
    for (int i = 0; i < 4; i++) loadFrame(0, 32'hF000_0000 + 32'(i * 16), 1);
    runUntilQuiet("t6", 200);
    for (int i = 0; i < 4; i++) expectFrame(32'hF000_0000 + 32'(i * 16), 1);
    compareOut("t6");
    // Handshake, one cycle back to idle, one grant cycle.
    for (int i = 1; i < 4 && i < s0FireCycle.size(); i++)
      checkOutput($sformatf("t6_spacing%0d", i), 64'(s0FireCycle[i] - s0FireCycle[i - 1]), 64'(3));
    clearLogs();

    // Fixed priority: S0 wins the tie even right after being served.
    $display("[TB] fixed-priority arbitration");
    loadFrame(0, 32'hA500_0000, 1);
    runUntilQuiet("t2fa", 200);
    loadFrame(0, 32'hA600_0000, 1);
    loadFrame(1, 32'hB600_0000, 1);
    runUntilQuiet("t2fb", 200);
    expectFrame(32'hA500_0000, 1);
    expectFrame(32'hA600_0000, 1);
    expectFrame(32'hB600_0000, 1);
    compareOut("t2f");
    clearLogs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
